// File: rtl/blake_round_counter.sv
// Round/step sequencer for the single-G BLAKE-512 core: G-step, round, sigma row and phase.
// Optional BLAKE_STALL_EN adds a stall input that freezes every counter and masks the pulses.
module blake_round_counter #(
   parameter int NUM_ROUNDS = 16,
   parameter int G_LAT      = 2
) (
   input  logic       clk,
   input  logic       rstb,
   input  logic       init_round,
   input  logic       round_ing,
`ifdef BLAKE_STALL_EN
   input  logic       stall,
`endif
   output logic [2:0] g_idx,
   output logic       diag,
   output logic [3:0] round_idx,
   output logic [3:0] sigma_row,
   output logic [2:0] sub_cnt,
   output logic       g_start,
   output logic       g_last,
   output logic       count_done
);

   localparam logic [2:0] SUB_LAST   = 3'(G_LAT - 1);
   localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS - 1);

   logic [2:0] sub_cnt_reg, sub_cnt_next;
   logic [2:0] g_idx_reg, g_idx_next;
   logic [3:0] round_idx_reg, round_idx_next;
   logic [3:0] sigma_row_reg, sigma_row_next;
   logic       stall_int;
   logic       advance;
   logic       sub_wrap;
   logic       step_wrap;
   logic       round_wrap;

`ifdef BLAKE_STALL_EN
   assign stall_int = stall;
`else
   assign stall_int = 1'b0;
`endif

   assign advance    = round_ing && !stall_int;
   assign sub_wrap   = (sub_cnt_reg == SUB_LAST);
   assign step_wrap  = sub_wrap && (g_idx_reg == 3'd7);
   assign round_wrap = step_wrap && (round_idx_reg == ROUND_LAST);

   always_comb begin
      sub_cnt_next   = sub_cnt_reg;
      g_idx_next     = g_idx_reg;
      round_idx_next = round_idx_reg;
      sigma_row_next = sigma_row_reg;
      if (init_round) begin
         sub_cnt_next   = 3'd0;
         g_idx_next     = 3'd0;
         round_idx_next = 4'd0;
         sigma_row_next = 4'd0;
      end else if (advance) begin
         if (sub_wrap) begin
            sub_cnt_next = 3'd0;
            g_idx_next   = g_idx_reg + 3'd1;
         end else begin
            sub_cnt_next = sub_cnt_reg + 3'd1;
         end
         // sigma row tracks round_idx mod 10 with a compare instead of a divider
         if (round_wrap) begin
            round_idx_next = 4'd0;
            sigma_row_next = 4'd0;
         end else if (step_wrap) begin
            round_idx_next = round_idx_reg + 4'd1;
            sigma_row_next = (sigma_row_reg == 4'd9) ? 4'd0 : sigma_row_reg + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         sub_cnt_reg   <= 3'd0;
         g_idx_reg     <= 3'd0;
         round_idx_reg <= 4'd0;
         sigma_row_reg <= 4'd0;
      end else begin
         sub_cnt_reg   <= sub_cnt_next;
         g_idx_reg     <= g_idx_next;
         round_idx_reg <= round_idx_next;
         sigma_row_reg <= sigma_row_next;
      end
   end

   assign g_idx      = g_idx_reg;
   assign round_idx  = round_idx_reg;
   assign sigma_row  = sigma_row_reg;
   assign sub_cnt    = sub_cnt_reg;
   assign diag       = g_idx_reg[2];
   assign g_start    = advance && (sub_cnt_reg == 3'd0);
   assign g_last     = advance && sub_wrap;
   // combinational so the controller exits on exactly the last step
   assign count_done = advance && round_wrap;

endmodule

// File: tb/tb_blake_round_counter.sv
// Self-checking bench for blake_round_counter: three parameterisations driven in lockstep
// against a position-based model (position = advancing cycles since the last init, mod run length).
module tb_blake_round_counter;

   logic clk = 1'b0;
   logic rstb = 1'b1;
   logic init_round = 1'b0;
   logic round_ing = 1'b0;
   logic stall_v = 1'b0;

   logic [2:0] a_g, b_g, c_g;
   logic       a_dg, b_dg, c_dg;
   logic [3:0] a_r, b_r, c_r;
   logic [3:0] a_s, b_s, c_s;
   logic [2:0] a_sc, b_sc, c_sc;
   logic       a_gs, b_gs, c_gs;
   logic       a_gl, b_gl, c_gl;
   logic       a_cd, b_cd, c_cd;

   int n_cmp = 0;
   int n_fail = 0;
   int pa = 0, pb = 0, pc = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   blake_round_counter #(.NUM_ROUNDS(16), .G_LAT(2)) u_dut (
      .clk(clk), .rstb(rstb), .init_round(init_round), .round_ing(round_ing),
`ifdef BLAKE_STALL_EN
      .stall(stall_v),
`endif
      .g_idx(a_g), .diag(a_dg), .round_idx(a_r), .sigma_row(a_s), .sub_cnt(a_sc),
      .g_start(a_gs), .g_last(a_gl), .count_done(a_cd));

   blake_round_counter #(.NUM_ROUNDS(1), .G_LAT(1)) u_small (
      .clk(clk), .rstb(rstb), .init_round(init_round), .round_ing(round_ing),
`ifdef BLAKE_STALL_EN
      .stall(stall_v),
`endif
      .g_idx(b_g), .diag(b_dg), .round_idx(b_r), .sigma_row(b_s), .sub_cnt(b_sc),
      .g_start(b_gs), .g_last(b_gl), .count_done(b_cd));

   blake_round_counter #(.NUM_ROUNDS(16), .G_LAT(8)) u_wide (
      .clk(clk), .rstb(rstb), .init_round(init_round), .round_ing(round_ing),
`ifdef BLAKE_STALL_EN
      .stall(stall_v),
`endif
      .g_idx(c_g), .diag(c_dg), .round_idx(c_r), .sigma_row(c_s), .sub_cnt(c_sc),
      .g_start(c_gs), .g_last(c_gl), .count_done(c_cd));

   // Model: only the count of advancing cycles matters; everything else is arithmetic on it.
   always @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         pa <= 0; pb <= 0; pc <= 0;
      end else if (init_round) begin
         pa <= 0; pb <= 0; pc <= 0;
      end else if (round_ing && !stall_v) begin
         pa <= (pa + 1) % (16 * 8 * 2);
         pb <= (pb + 1) % (1 * 8 * 1);
         pc <= (pc + 1) % (16 * 8 * 8);
      end
   end

   task automatic check_inst(input string nm, input int nr, input int gl, input int p,
                             input logic [2:0] g, input logic dg, input logic [3:0] r,
                             input logic [3:0] s, input logic [2:0] sc, input logic gs,
                             input logic gls, input logic cd);
      int e_sub, e_g, e_r, e_s;
      logic act, e_gs, e_gl, e_cd, e_dg;
      logic [18:0] exp_v, act_v;
      e_sub = p % gl;
      e_g   = (p / gl) % 8;
      e_r   = p / (8 * gl);
      e_s   = e_r % 10;
      act   = round_ing && !stall_v;
      e_gs  = act && (e_sub == 0);
      e_gl  = act && (e_sub == gl - 1);
      e_cd  = e_gl && (e_g == 7) && (e_r == nr - 1);
      e_dg  = (e_g >= 4);
      exp_v = {3'(e_g), e_dg, 4'(e_r), 4'(e_s), 3'(e_sub), e_gs, e_gl, e_cd};
      act_v = {g, dg, r, s, sc, gs, gls, cd};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s t=%0t {g,diag,round,sigma,sub,gs,gl,done} got %0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d",
                  nm, $time, g, dg, r, s, sc, gs, gls, cd, e_g, e_dg, e_r, e_s, e_sub, e_gs, e_gl, e_cd);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check_inst("model_main",  16, 2, pa, a_g, a_dg, a_r, a_s, a_sc, a_gs, a_gl, a_cd);
         check_inst("model_small",  1, 1, pb, b_g, b_dg, b_r, b_s, b_sc, b_gs, b_gl, b_cd);
         check_inst("model_wide",  16, 8, pc, c_g, c_dg, c_r, c_s, c_sc, c_gs, c_gl, c_cd);
      end
   end

   task automatic lit(input string nm, input int actual, input int expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, actual, expected);
      end
   endtask

   // Inputs change just after the rising edge; returns at the falling edge of that cycle.
   task automatic step(input logic ini, input logic ri, input logic st);
      @(posedge clk);
      #1;
      init_round = ini;
      round_ing  = ri;
`ifdef BLAKE_STALL_EN
      stall_v    = st;
`else
      stall_v    = 1'b0 & st;
`endif
      @(negedge clk);
   endtask

   function automatic int all_outs();
      return int'({a_g, a_dg, a_r, a_s, a_sc, a_gs, a_gl, a_cd});
   endfunction

   initial begin
      int gs_cnt, cd_cnt, cd_at;
      #2 rstb = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      lit("reset_outputs", all_outs(), 0);
      step(0, 0, 0);
      @(posedge clk);
      #1 rstb = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0);
         lit("idle_outputs", all_outs(), 0);
      end

      // Full default run: init at T, round_ing for 256 cycles
      step(1, 0, 0);
      gs_cnt = 0; cd_cnt = 0; cd_at = -1;
      for (int i = 0; i < 256; i++) begin
         step(0, 1, 0);
         if (a_gs) gs_cnt++;
         if (a_cd) begin cd_cnt++; cd_at = i; end
         if (i == 0)   lit("first_g_start", int'(a_gs), 1);
         if (i == 144) lit("sigma_round9", int'(a_s), 9);
         if (i == 160) lit("sigma_wrap_round10", int'(a_s), 0);
         if (i == 240) lit("sigma_round15", int'(a_s), 5);
         if (i == 6)   lit("small_no_done_7th", int'(b_cd), 0);
         if (i == 7)   lit("small_done_8th", int'(b_cd), 1);
         if (i == 8)   lit("wide_g_start_8", int'(c_gs), 1);
         if (i == 9)   lit("wide_no_g_start_9", int'(c_gs), 0);
         if (i == 255) begin
            lit("last_round_idx", int'(a_r), 15);
            lit("last_g_idx", int'(a_g), 7);
            lit("last_sub_cnt", int'(a_sc), 1);
         end
      end
      lit("done_count", cd_cnt, 1);
      lit("done_position", cd_at, 255);
      lit("g_start_count", gs_cnt, 128);
      step(0, 0, 0);
      lit("counters_after_run", int'({a_g, a_r, a_s, a_sc}), 0);

      // Re-init mid-run at round 4, step 3, with round_ing still high
      step(1, 0, 0);
      for (int i = 0; i < 70; i++) step(0, 1, 0);
      step(1, 1, 0);
      lit("reinit_at_g3", int'(a_g), 3);
      lit("reinit_at_r4", int'(a_r), 4);
      cd_at = -1;
      for (int j = 0; j < 256; j++) begin
         step(0, 1, 0);
         if (j == 0) lit("reinit_cleared", int'({a_g, a_r, a_s, a_sc}), 0);
         if (a_cd && cd_at < 0) cd_at = j;
      end
      lit("reinit_done_position", cd_at, 255);
      step(0, 0, 0);

`ifdef BLAKE_STALL_EN
      // Five-cycle stall at round 7 step 2 delays completion by five cycles
      step(1, 0, 0);
      cd_at = -1;
      for (int k = 0; k < 261; k++) begin
         step(0, 1, (k >= 116 && k < 121));
         if (k == 118) begin
            lit("stall_frozen_g", int'(a_g), 2);
            lit("stall_frozen_r", int'(a_r), 7);
            lit("stall_no_g_start", int'(a_gs), 0);
         end
         if (a_cd && cd_at < 0) cd_at = k;
      end
      lit("stall_done_position", cd_at, 260);
      step(0, 0, 0);
`endif

      // Asynchronous reset in the middle of a run
      step(1, 0, 0);
      for (int i = 0; i < 50; i++) step(0, 1, 0);
      @(posedge clk);
      #3;
      rstb = 1'b0;
      round_ing = 1'b0;
      #1;
      lit("async_reset_clears", all_outs(), 0);
      @(negedge clk);
      step(0, 0, 0);
      @(posedge clk);
      #1 rstb = 1'b1;
      @(negedge clk);

      // Randomised traffic, including dropped round_ing and re-inits
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 15) == 0));
      end
      step(0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
